// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception controller.
package exc_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  localparam logic [3:0]  ESR_NONE   = 4'h0;
  localparam logic [3:0]  ESR_BAD_OP = 4'h1;
  localparam logic [3:0]  ESR_IRQ    = 4'h2;

  localparam logic [63:0] VECTOR_BASE_DEFAULT = 64'h0000_0000_0000_00D8;

  // Invalid opcode wins over a pending interrupt.
  function automatic logic [3:0] esr_code(input logic bad_op, input logic irq);
    if (bad_op)   return ESR_BAD_OP;
    else if (irq) return ESR_IRQ;
    else          return ESR_NONE;
  endfunction

endpackage

// File: rtl/flopr_e.sv
// Enable flip-flop with asynchronous active-high reset.
module flopr_e #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/irq_pend_latch.sv
// Rising-edge detector on the interrupt level plus the pending-request latch.
module irq_pend_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq_i,
  input  logic clr,
  output logic pend
);

  logic irq_prev;
  logic irq_rise;

  assign irq_rise = irq_i & ~irq_prev;

  // A new edge on the clearing edge wins, so no request is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev <= 1'b0;
      pend     <= 1'b0;
    end else begin
      irq_prev <= irq_i;
      pend     <= irq_rise | (pend & ~clr);
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: RUN/HANDLER FSM, ELR/ESR capture, IRQ acknowledge,
// sticky fault flag and saturating exception counter.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [63:0] VECTOR_BASE = VECTOR_BASE_DEFAULT,
  parameter int          CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq_i,
  input  logic             bad_op_i,
  input  logic             eret_i,
  input  logic [63:0]      pc_i,
  output logic             exc_o,
  output logic             eret_o,
  output logic [63:0]      vector_o,
  output logic [63:0]      elr_o,
  output logic [3:0]       esr_o,
  output logic             irq_ack_o,
  output logic             in_handler_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] exc_cnt_o
);

  state_t     state;
  logic       irq_pend;
  logic       irq_take;
  logic       esr_en;
  logic [3:0] esr_d;

  irq_pend_latch u_irq_pend (
    .clk   (clk),
    .reset (reset),
    .irq_i (irq_i),
    .clr   (irq_take),
    .pend  (irq_pend)
  );

  // Exceptions only in RUN and returns only in HANDLER, so the two are exclusive.
  assign exc_o    = (state == RUN) & (bad_op_i | irq_pend);
  assign irq_take = (state == RUN) & ~bad_op_i & irq_pend;
  assign eret_o   = (state == HANDLER) & eret_i;

  assign vector_o     = VECTOR_BASE;
  assign in_handler_o = (state == HANDLER);

  flopr_e #(.W(64)) u_elr (
    .clk   (clk),
    .reset (reset),
    .en    (exc_o),
    .d     (pc_i),
    .q     (elr_o)
  );

  assign esr_en = exc_o | eret_o;
  assign esr_d  = exc_o ? esr_code(bad_op_i, irq_pend) : ESR_NONE;

  flopr_e #(.W(4)) u_esr (
    .clk   (clk),
    .reset (reset),
    .en    (esr_en),
    .d     (esr_d),
    .q     (esr_o)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      irq_ack_o <= 1'b0;
      fault_o   <= 1'b0;
      exc_cnt_o <= '0;
    end else begin
      irq_ack_o <= irq_take;
      case (state)
        RUN: begin
          if (exc_o) begin
            state <= HANDLER;
            if (exc_cnt_o != '1) exc_cnt_o <= exc_cnt_o + CNT_W'(1);
          end
        end
        HANDLER: begin
          if (bad_op_i) fault_o <= 1'b1;
          if (eret_i)   state   <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq_i, bad_op_i, eret_i;
  logic [63:0] pc_i;

  logic        exc_o, eret_o, irq_ack_o, in_handler_o, fault_o;
  logic [63:0] vector_o, elr_o;
  logic [3:0]  esr_o;
  logic [7:0]  exc_cnt_o;

  logic        exc2, eret2, ack2, inh2, fault2;
  logic [63:0] vec2, elr2;
  logic [3:0]  esr2;
  logic [1:0]  cnt2;

  int total = 0;
  int bad   = 0;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .irq_i(irq_i), .bad_op_i(bad_op_i), .eret_i(eret_i),
    .pc_i(pc_i), .exc_o(exc_o), .eret_o(eret_o), .vector_o(vector_o), .elr_o(elr_o),
    .esr_o(esr_o), .irq_ack_o(irq_ack_o), .in_handler_o(in_handler_o),
    .fault_o(fault_o), .exc_cnt_o(exc_cnt_o)
  );

  exc_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .irq_i(irq_i), .bad_op_i(bad_op_i), .eret_i(eret_i),
    .pc_i(pc_i), .exc_o(exc2), .eret_o(eret2), .vector_o(vec2), .elr_o(elr2),
    .esr_o(esr2), .irq_ack_o(ack2), .in_handler_o(inh2),
    .fault_o(fault2), .exc_cnt_o(cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the architecture must look like after each edge.
  bit          m_hand  = 0;
  bit          m_pend  = 0;
  bit          m_prev  = 0;
  bit          m_ack   = 0;
  bit          m_fault = 0;
  logic [63:0] m_elr   = '0;
  logic [3:0]  m_esr   = '0;
  int          m_count = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hand = 0; m_pend = 0; m_prev = 0; m_ack = 0; m_fault = 0;
      m_elr = '0; m_esr = '0; m_count = 0;
    end else begin
      bit took_irq;
      bit rise;
      took_irq = 0;
      rise     = irq_i && !m_prev;
      if (!m_hand) begin
        if (bad_op_i || m_pend) begin
          m_elr   = pc_i;
          m_esr   = bad_op_i ? 4'h1 : 4'h2;
          took_irq = !bad_op_i;
          m_hand  = 1;
          m_count = m_count + 1;
        end
      end else begin
        if (bad_op_i) m_fault = 1;
        if (eret_i) begin
          m_hand = 0;
          m_esr  = 4'h0;
        end
      end
      m_ack  = took_irq;
      m_pend = rise || (m_pend && !took_irq);
      m_prev = irq_i;
    end
  end

  always @(negedge clk) begin
    bit exp_exc, exp_eret;
    exp_exc  = !m_hand && (bad_op_i || m_pend);
    exp_eret = m_hand && eret_i;
    check("cyc_exc",    exc_o,        exp_exc);
    check("cyc_eret",   eret_o,       exp_eret);
    check("cyc_elr",    elr_o,        m_elr);
    check("cyc_esr",    esr_o,        m_esr);
    check("cyc_ack",    irq_ack_o,    m_ack);
    check("cyc_inh",    in_handler_o, m_hand);
    check("cyc_fault",  fault_o,      m_fault);
    check("cyc_cnt",    exc_cnt_o,    (m_count > 255) ? 255 : m_count);
    check("cyc_vector", vector_o,     64'hD8);
    check("cyc_cnt2",   cnt2,         (m_count > 3) ? 3 : m_count);
    check("cyc_exc2",   exc2,         exp_exc);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; irq_i = 1'b0; bad_op_i = 1'b0; eret_i = 1'b0; pc_i = '0;
    repeat (3) next();
    check("rst_elr", elr_o, 0);
    check("rst_esr", esr_o, 0);
    check("rst_inh", in_handler_o, 0);
    check("rst_cnt", exc_cnt_o, 0);
    check("rst_ack", irq_ack_o, 0);
    check("rst_fault", fault_o, 0);
    reset = 1'b0;
    next();

    // Invalid opcode in RUN.
    bad_op_i = 1'b1; pc_i = 64'h40; #1;
    check("op_exc", exc_o, 1);
    next(); bad_op_i = 1'b0;
    check("op_elr", elr_o, 64'h40);
    check("op_esr", esr_o, 4'h1);
    check("op_inh", in_handler_o, 1);
    check("op_cnt", exc_cnt_o, 1);
    eret_i = 1'b1; #1;
    check("op_eret", eret_o, 1);
    check("op_eret_noexc", exc_o, 0);
    next(); eret_i = 1'b0;
    check("op_back_run", in_handler_o, 0);
    check("op_esr_clr", esr_o, 4'h0);

    // Interrupt edge in RUN.
    irq_i = 1'b1; pc_i = 64'h100;
    next(); #1;
    check("irq_exc", exc_o, 1);
    next();
    check("irq_elr", elr_o, 64'h100);
    check("irq_esr", esr_o, 4'h2);
    check("irq_ack_hi", irq_ack_o, 1);
    next();
    check("irq_ack_lo", irq_ack_o, 0);

    // Interrupt edge while in HANDLER is deferred past ERET.
    irq_i = 1'b0;
    next(); irq_i = 1'b1;
    next(); eret_i = 1'b1; pc_i = 64'h200; #1;
    check("defer_eret", eret_o, 1);
    check("defer_noexc", exc_o, 0);
    next(); eret_i = 1'b0; #1;
    check("defer_exc", exc_o, 1);
    next();
    check("defer_esr", esr_o, 4'h2);
    check("defer_elr", elr_o, 64'h200);
    eret_i = 1'b1;
    next(); eret_i = 1'b0; irq_i = 1'b0;

    // Opcode and pending IRQ together: opcode first, IRQ after ERET.
    next(); irq_i = 1'b1;
    next(); bad_op_i = 1'b1; pc_i = 64'h300; #1;
    check("both_exc", exc_o, 1);
    next(); bad_op_i = 1'b0;
    check("both_esr_op", esr_o, 4'h1);
    eret_i = 1'b1;
    next(); eret_i = 1'b0; #1;
    check("both_irq_exc", exc_o, 1);
    next();
    check("both_esr_irq", esr_o, 4'h2);
    eret_i = 1'b1;
    next(); eret_i = 1'b0;

    // ERET ignored in RUN; opcode in HANDLER sets fault.
    eret_i = 1'b1; #1;
    check("run_eret", eret_o, 0);
    next(); eret_i = 1'b0;
    check("run_eret_state", in_handler_o, 0);
    bad_op_i = 1'b1; pc_i = 64'h500;
    next(); #1;
    check("hnd_op_noexc", exc_o, 0);
    next(); bad_op_i = 1'b0; irq_i = 1'b0;
    check("hnd_fault", fault_o, 1);
    check("hnd_inh", in_handler_o, 1);

    // Short reset pulse between edges abandons the handler.
    #2 reset = 1'b1; #1;
    check("pulse_inh", in_handler_o, 0);
    check("pulse_fault", fault_o, 0);
    check("pulse_elr", elr_o, 0);
    check("pulse_esr", esr_o, 0);
    check("pulse_cnt", exc_cnt_o, 0);
    check("pulse_cnt2", cnt2, 0);
    #2 reset = 1'b0;
    next(); eret_i = 1'b1; #1;
    check("pulse_no_eret", eret_o, 0);
    next(); eret_i = 1'b0;

    // Four exceptions saturate the 2-bit counter.
    repeat (4) begin
      bad_op_i = 1'b1;
      next(); bad_op_i = 1'b0; eret_i = 1'b1;
      next(); eret_i = 1'b0;
    end
    check("sat_cnt2", cnt2, 2'b11);
    check("sat_cnt", exc_cnt_o, 4);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      next();
      if ($urandom_range(0, 5) == 0) irq_i = ~irq_i;
      bad_op_i = ($urandom_range(0, 7) == 0);
      eret_i   = ($urandom_range(0, 2) == 0);
      pc_i     = {$urandom, $urandom};
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #3 reset = 1'b0;
      end
    end

    next();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
